soc_imem_loader: RTL and testbench

- Boot/reload controller that sequences the CPU wrapper's IMEM write port from a byte stream (UART RX or debug bridge).
- Parses a framed image, assembles little-endian 32-bit words, issues single-cycle IMEM writes and holds the CPU in reset for the whole load.
- Sits between the byte-stream source and the soc_cpu reload port (imem_we/imem_waddr/imem_wdat).
- Its cpu_rst_n output gates the CPU reset.

---
 rtl/soc_imem_loader.sv | 146 ++++++++++++++
 tb/tb_soc_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_imem_loader.sv
// Boot/reload controller: parses a framed byte stream into little-endian 32-bit IMEM writes
// and holds the CPU in reset while an image is being loaded.
module soc_imem_loader #(
  parameter int unsigned IMEM_WORDS = 4096,
  parameter logic [29:0] BASE_WADDR = 30'h0,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter bit          BOOT_HOLD  = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_vld_i,
  input  logic [7:0]  rx_dat_i,
  output logic        rx_rdy_o,
  output logic        imem_we_o,
  output logic [29:0] imem_waddr_o,
  output logic [31:0] imem_wdat_o,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_loaded_o
);

  localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [7:0]     Header  = 8'hA5;

  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StCsum, StErr} state_e;

  state_e          state_q;
  logic [15:0]     len_q;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     asm_q;
  logic [7:0]      sum_q;
  logic [CntW-1:0] cnt_q;

  logic [15:0] len_n;
  logic        timeout;

  assign rx_rdy_o = 1'b1;
  assign len_n    = {rx_dat_i, len_q[7:0]};
  // Fires on the TIMEOUT-th consecutive idle cycle inside a frame.
  assign timeout  = !rx_vld_i && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= StIdle;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      sum_q          <= '0;
      cnt_q          <= '0;
      imem_we_o      <= 1'b0;
      imem_waddr_o   <= BASE_WADDR;
      imem_wdat_o    <= '0;
      cpu_rst_n_o    <= ~BOOT_HOLD;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      words_loaded_o <= '0;
    end else begin
      imem_we_o <= 1'b0;
      done_o    <= 1'b0;

      if (rx_vld_i || state_q == StIdle || state_q == StErr) begin
        cnt_q <= '0;
      end else if (cnt_q != CntLast) begin
        cnt_q <= cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (rx_vld_i && rx_dat_i == Header) begin
            state_q        <= StLen0;
            cpu_rst_n_o    <= 1'b0;
            busy_o         <= 1'b1;
            err_o          <= 1'b0;
            words_loaded_o <= '0;
            sum_q          <= '0;
            byte_cnt_q     <= '0;
          end
        end
        StLen0: begin
          if (timeout) begin
            state_q <= StErr;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else if (rx_vld_i) begin
            len_q[7:0] <= rx_dat_i;
            state_q    <= StLen1;
          end
        end
        StLen1: begin
          if (timeout || (rx_vld_i && {16'h0, len_n} > IMEM_WORDS)) begin
            state_q <= StErr;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else if (rx_vld_i) begin
            len_q   <= len_n;
            state_q <= (len_n == 16'd0) ? StCsum : StData;
          end
        end
        StData: begin
          // A partial word is simply dropped when the timeout fires.
          if (timeout) begin
            state_q <= StErr;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else if (rx_vld_i) begin
            sum_q      <= sum_q + rx_dat_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {rx_dat_i, asm_q[23:8]};
            if (byte_cnt_q == 2'd3) begin
              imem_we_o      <= 1'b1;
              imem_waddr_o   <= BASE_WADDR + 30'(words_loaded_o);
              imem_wdat_o    <= {rx_dat_i, asm_q};
              words_loaded_o <= words_loaded_o + 16'd1;
              if (words_loaded_o == len_q - 16'd1) begin
                state_q <= StCsum;
              end
            end
          end
        end
        StCsum: begin
          if (timeout || (rx_vld_i && rx_dat_i != sum_q)) begin
            state_q <= StErr;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else if (rx_vld_i) begin
            state_q     <= StIdle;
            done_o      <= 1'b1;
            cpu_rst_n_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_imem_loader.sv
// Directed bench for soc_imem_loader: per-cycle vector table plus timeout and reset sequences.
module tb_soc_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        rx_vld;
  logic [7:0]  rx_dat;

  logic        a_rdy, a_we, a_rst_n, a_busy, a_done, a_err;
  logic [29:0] a_waddr;
  logic [31:0] a_wdat;
  logic [15:0] a_wl;
  logic        b_rdy, b_we, b_rst_n, b_busy, b_done, b_err;
  logic [29:0] b_waddr;
  logic [31:0] b_wdat;
  logic [15:0] b_wl;

  soc_imem_loader #(
    .IMEM_WORDS(4), .BASE_WADDR(30'h0), .TIMEOUT(16), .BOOT_HOLD(1'b1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .rx_vld_i(rx_vld), .rx_dat_i(rx_dat), .rx_rdy_o(a_rdy),
    .imem_we_o(a_we), .imem_waddr_o(a_waddr), .imem_wdat_o(a_wdat), .cpu_rst_n_o(a_rst_n),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .words_loaded_o(a_wl)
  );

  // Second instance: base address at the top of the 30-bit space, no boot hold.
  soc_imem_loader #(
    .IMEM_WORDS(4), .BASE_WADDR(30'h3FFF_FFFF), .TIMEOUT(16), .BOOT_HOLD(1'b0)
  ) dut_b (
    .clk(clk), .resetn(resetn), .rx_vld_i(rx_vld), .rx_dat_i(rx_dat), .rx_rdy_o(b_rdy),
    .imem_we_o(b_we), .imem_waddr_o(b_waddr), .imem_wdat_o(b_wdat), .cpu_rst_n_o(b_rst_n),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .words_loaded_o(b_wl)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        we;
    logic [29:0] waddr;
    logic [31:0] wdat;
    logic        rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] wl;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   we_cnt = 0;

  always begin
    @(posedge clk);
    #2;
    if (a_we) we_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic vld, input logic [7:0] dat, input logic we,
                              input logic [29:0] waddr, input logic [31:0] wdat,
                              input logic rst_n, input logic busy, input logic done,
                              input logic err, input logic [15:0] wl);
    vec_t v;
    v.vld = vld; v.dat = dat; v.we = we; v.waddr = waddr; v.wdat = wdat;
    v.rst_n = rst_n; v.busy = busy; v.done = done; v.err = err; v.wl = wl;
    vecs.push_back(v);
  endfunction

  // Words 0x11223344 and 0xDEADBEEF; payload sum mod 256 is 0xE2.
  function automatic void add_two_word(input logic [7:0] cs);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h44, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h33, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h22, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h11, 1, 30'd0, 32'h1122_3344, 0, 1, 0, 0, 1);
    add(1, 8'hEF, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hBE, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hAD, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hDE, 1, 30'd1, 32'hDEAD_BEEF, 0, 1, 0, 0, 2);
    if (cs == 8'hE2) begin
      add(1, cs, 0, 0, 0, 1, 0, 1, 0, 2);
      add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 2);
    end else begin
      add(1, cs, 0, 0, 0, 0, 0, 0, 1, 2);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2);
    end
  endfunction

  task automatic send(input logic [7:0] b);
    rx_vld = 1'b1;
    rx_dat = b;
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a ctl"}, {a_rdy, a_we, a_rst_n, a_busy, a_done, a_err, a_wl},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    chk({tag, " a waddr"}, a_waddr, 30'h0);
    chk({tag, " a wdat"}, a_wdat, 32'h0);
    chk({tag, " b rst_n/waddr"}, {b_rst_n, b_waddr}, {1'b1, 30'h3FFF_FFFF});
  endtask

  initial begin
    int w0;
    resetn = 1'b0;
    rx_vld = 1'b0;
    rx_dat = 8'h00;

    add_two_word(8'hE2);
    add_two_word(8'hE3);
    add_two_word(8'hE2);
    // Zero-length frame
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
    // Oversize: N=5, then N=256
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h05, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    // Noise in idle
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h5A, 0, 0, 0, 0, 0, 0, 1, 0);
    // 0xA5 as LEN_LO is length data: N=0x00A5 is oversize
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    // 0xA5 as payload: word 0xA5A5A5A5, csum 0x94
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'hA5, 1, 30'd0, 32'hA5A5_A5A5, 0, 1, 0, 0, 1);
    add(1, 8'h94, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rx_vld = vecs[i].vld;
      rx_dat = vecs[i].dat;
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i), {a_we, a_rst_n, a_busy, a_done, a_err, a_wl},
          {vecs[i].we, vecs[i].rst_n, vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].wl});
      chk($sformatf("vec%0d b we/wl", i), {b_we, b_wl}, {vecs[i].we, vecs[i].wl});
      if (vecs[i].we) begin
        chk($sformatf("vec%0d a addr/data", i), {a_waddr, a_wdat},
            {vecs[i].waddr, vecs[i].wdat});
        chk($sformatf("vec%0d b addr/data", i), {b_waddr, b_wdat},
            {vecs[i].waddr + 30'h3FFF_FFFF, vecs[i].wdat});
      end
    end
    rx_vld = 1'b0;

    // Timeout with a partial word pending
    send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    w0 = we_cnt;
    repeat (15) @(negedge clk);
    chk("timeout before limit busy/err", {a_busy, a_err}, 2'b10);
    @(negedge clk);
    chk("timeout hit busy/err/rst_n", {a_busy, a_err, a_rst_n}, 3'b010);
    @(negedge clk);
    chk("timeout no write", we_cnt, w0);
    send(8'hA5);
    chk("restart clears err", {a_busy, a_err}, 2'b10);
    send(8'h00); send(8'h00); send(8'h00);
    chk("restart done", {a_done, a_rst_n, a_busy, a_err}, 4'b1100);

    // Reset mid-DATA with the 4th byte presented in the reset cycle
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    w0 = we_cnt;
    resetn = 1'b0;
    rx_vld = 1'b1;
    rx_dat = 8'h44;
    @(negedge clk);
    chk_reset_vals("mid-frame reset");
    resetn = 1'b1;
    @(negedge clk);
    rx_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-reset no write", we_cnt, w0);
    chk("post-reset idle", {a_busy, a_rst_n, a_wl}, {1'b0, 1'b0, 16'h0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
